// File: rtl/as_bus_resp_if.sv
// Bus bundle between the core-side address decoder, the access controller
// and the downstream slaves (RAM, GPIO, QSPI, CGU).
interface as_bus_resp_if #(
  parameter int DW = 64,
  parameter int CS = 4
);
  // Core request side
  logic             req_i;
  logic             we_i;
  logic [DW-1:0]    wdata_i;
  logic [CS-1:0]    cs_i;
  // Slave side
  logic [CS-1:0]    sel_o;
  logic             we_o;
  logic [DW-1:0]    wdata_o;
  logic [CS*DW-1:0] slv_rdata_i;
  logic [CS-1:0]    slv_ack_i;
  // Core response side
  logic [DW-1:0]    rdata_o;
  logic             ack_o;
  logic             err_o;
  logic             busy_o;

  // The access controller itself
  modport slave (
    input  req_i, we_i, wdata_i, cs_i, slv_rdata_i, slv_ack_i,
    output sel_o, we_o, wdata_o, rdata_o, ack_o, err_o, busy_o
  );

  // Whoever drives requests and models the slaves
  modport master (
    output req_i, we_i, wdata_i, cs_i, slv_rdata_i, slv_ack_i,
    input  sel_o, we_o, wdata_o, rdata_o, ack_o, err_o, busy_o
  );
endinterface

// File: rtl/as_bus_resp.sv
// Data-bus access controller: registers a one-hot chip-select access towards
// one slave, waits for its acknowledge (bounded by TIMEOUT cycles) and
// returns a single-cycle ack/err pulse plus read data to the core.
module as_bus_resp #(
  parameter int DW      = 64,
  parameter int CS      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  as_bus_resp_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // A chip-select vector is usable only if exactly one slave is addressed.
  function automatic logic is_onehot(input logic [CS-1:0] v);
    return (v != {CS{1'b0}}) &&
           ((v & (v - {{(CS-1){1'b0}}, 1'b1})) == {CS{1'b0}});
  endfunction

  state_e         state_q;
  logic [CS-1:0]  sel_q;
  logic           we_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rdata_q;
  logic           ack_q;
  logic           err_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;

  logic [CS-1:0]  hit_s;
  logic           hit_any_s;
  logic [DW-1:0]  hit_data_s;
  logic [CW-1:0]  cnt_inc_s;
  logic           timeout_s;

  // Only an acknowledge from the currently selected slave counts.
  always_comb begin
    hit_s      = bus.slv_ack_i & sel_q;
    hit_any_s  = (hit_s != {CS{1'b0}});
    cnt_inc_s  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    timeout_s  = (cnt_inc_s == CW'(TIMEOUT));
    hit_data_s = {DW{1'b0}};
    for (int n = 0; n < CS; n++) begin
      hit_data_s = hit_data_s | ({DW{hit_s[n]}} & bus.slv_rdata_i[n*DW +: DW]);
    end
  end

  // Access FSM; every output is a register updated on the transition.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= {CS{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DW{1'b0}};
      rdata_q <= {DW{1'b0}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_i) begin
            busy_q <= 1'b1;
            if (is_onehot(bus.cs_i)) begin
              sel_q   <= bus.cs_i;
              we_q    <= bus.we_i;
              wdata_q <= bus.wdata_i;
              cnt_q   <= {CW{1'b0}};
              state_q <= ST_ACCESS;
            end else begin
              // Unmapped: answer with an error without touching any slave.
              sel_q   <= {CS{1'b0}};
              we_q    <= 1'b0;
              rdata_q <= {DW{1'b0}};
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_inc_s;
          if (hit_any_s) begin
            // Acknowledge wins over a timeout in the same cycle.
            if (!we_q) begin
              rdata_q <= hit_data_s;
            end else begin
              rdata_q <= rdata_q;
            end
            sel_q   <= {CS{1'b0}};
            we_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (timeout_s) begin
            sel_q   <= {CS{1'b0}};
            we_q    <= 1'b0;
            rdata_q <= {DW{1'b0}};
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          busy_q  <= 1'b0;
          rdata_q <= {DW{1'b0}};
          state_q <= ST_IDLE;
        end
        default: begin
          sel_q   <= {CS{1'b0}};
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.we_o    = we_q;
  assign bus.wdata_o = wdata_q;
  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_as_bus_resp.sv
// Bench for as_bus_resp: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_as_bus_resp;
  localparam int DW      = 64;
  localparam int CS      = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  as_bus_resp_if #(.DW(DW), .CS(CS)) bus ();

  as_bus_resp #(.DW(DW), .CS(CS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference model: one outstanding access with an age, and a response slot.
  logic [CS-1:0] m_sel      = '0;
  logic          m_we       = 1'b0;
  logic [DW-1:0] m_wdata    = '0;
  logic [DW-1:0] m_rdata    = '0;
  bit            m_inflight = 1'b0;
  bit            m_respond  = 1'b0;
  bit            m_err      = 1'b0;
  int            m_age      = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply the rules for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [CS-1:0] hit;
    if (!rst_n) begin
      m_sel = '0; m_we = 1'b0; m_wdata = '0; m_rdata = '0;
      m_inflight = 1'b0; m_respond = 1'b0; m_err = 1'b0; m_age = 0;
    end else if (m_respond) begin
      m_respond = 1'b0;
      if (m_err) m_rdata = '0;
      m_err = 1'b0;
    end else if (m_inflight) begin
      m_age++;
      hit = bus.slv_ack_i & m_sel;
      if (hit != '0) begin
        if (!m_we)
          for (int n = 0; n < CS; n++)
            if (hit[n]) m_rdata = bus.slv_rdata_i[n*DW +: DW];
        m_inflight = 1'b0; m_sel = '0; m_we = 1'b0;
        m_respond = 1'b1; m_err = 1'b0;
      end else if (m_age == TIMEOUT) begin
        m_inflight = 1'b0; m_sel = '0; m_we = 1'b0; m_rdata = '0;
        m_respond = 1'b1; m_err = 1'b1;
      end
    end else if (bus.req_i) begin
      if ($countones(bus.cs_i) == 1) begin
        m_inflight = 1'b1; m_sel = bus.cs_i; m_we = bus.we_i;
        m_wdata = bus.wdata_i; m_age = 0;
      end else begin
        m_respond = 1'b1; m_err = 1'b1; m_rdata = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel_o",   DW'(bus.sel_o),   DW'(m_sel));
      check("we_o",    DW'(bus.we_o),    DW'(m_we));
      check("wdata_o", bus.wdata_o,      m_wdata);
      check("rdata_o", bus.rdata_o,      m_rdata);
      check("ack_o",   DW'(bus.ack_o),   DW'(m_respond));
      check("err_o",   DW'(bus.err_o),   DW'(m_err));
      check("busy_o",  DW'(bus.busy_o),  DW'(m_inflight | m_respond));
    end
  end

  task automatic idle_inputs();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.wdata_i = '0; bus.cs_i = '0;
    bus.slv_ack_i = '0;
  endtask

  task automatic request(input logic we, input logic [CS-1:0] cs, input logic [DW-1:0] wd);
    bus.req_i = 1'b1; bus.we_i = we; bus.cs_i = cs; bus.wdata_i = wd;
  endtask

  int cyc;

  initial begin
    idle_inputs();
    bus.slv_rdata_i = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_busy", DW'(bus.busy_o), 64'd0);
    check("rst_rdata", bus.rdata_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // Read RAM, slave ack in cycle 3
    bus.slv_rdata_i[0*DW +: DW] = 64'hDEADBEEF_CAFEF00D;
    request(1'b0, 4'b0001, 64'd0);
    tick();                       // cycle 1
    bus.req_i = 1'b0;
    check("rd_sel_c1", DW'(bus.sel_o), 64'd1);
    tick(); tick();               // cycle 3
    check("rd_sel_c3", DW'(bus.sel_o), 64'd1);
    bus.slv_ack_i = 4'b0001;
    tick();                       // cycle 4
    bus.slv_ack_i = 4'b0000;
    check("rd_ack", DW'(bus.ack_o), 64'd1);
    check("rd_err", DW'(bus.err_o), 64'd0);
    check("rd_data", bus.rdata_o, 64'hDEADBEEF_CAFEF00D);
    tick();
    check("rd_idle_busy", DW'(bus.busy_o), 64'd0);

    // Write GPIO, ack in cycle 1
    request(1'b1, 4'b0010, 64'h5A);
    tick();                       // cycle 1
    idle_inputs();
    check("wr_we", DW'(bus.we_o), 64'd1);
    check("wr_wdata", bus.wdata_o, 64'h5A);
    bus.slv_ack_i = 4'b0010;
    tick();                       // cycle 2
    bus.slv_ack_i = 4'b0000;
    check("wr_ack", DW'(bus.ack_o), 64'd1);
    check("wr_rdata_kept", bus.rdata_o, 64'hDEADBEEF_CAFEF00D);
    tick();

    // Unmapped: no select, then two selects
    request(1'b0, 4'b0000, 64'd0);
    tick();
    bus.req_i = 1'b0;
    check("um0_ack", DW'(bus.ack_o), 64'd1);
    check("um0_err", DW'(bus.err_o), 64'd1);
    check("um0_sel", DW'(bus.sel_o), 64'd0);
    check("um0_rdata", bus.rdata_o, 64'd0);
    tick();
    request(1'b0, 4'b0110, 64'd0);
    tick();
    bus.req_i = 1'b0;
    check("um6_ack", DW'(bus.ack_o), 64'd1);
    check("um6_err", DW'(bus.err_o), 64'd1);
    check("um6_sel", DW'(bus.sel_o), 64'd0);
    tick();

    // Timeout on QSPI
    request(1'b0, 4'b0100, 64'd0);
    tick();
    bus.req_i = 1'b0;
    cyc = 1;
    while (!bus.ack_o && cyc < 40) begin
      if (cyc == 16) check("to_sel_c16", DW'(bus.sel_o), 64'd4);
      tick();
      cyc++;
    end
    check("to_cycle", DW'(cyc), 64'd17);
    check("to_err", DW'(bus.err_o), 64'd1);
    tick();
    check("to_busy_c18", DW'(bus.busy_o), 64'd0);

    // CGU access, spurious ack, req held high throughout
    bus.slv_rdata_i[3*DW +: DW] = 64'h0123_4567_89AB_CDEF;
    request(1'b0, 4'b1000, 64'd0);
    tick();                       // cycle 1
    tick();                       // cycle 2
    bus.slv_ack_i = 4'b0001;
    tick();                       // cycle 3
    bus.slv_ack_i = 4'b0000;
    check("sp_still_busy", DW'(bus.busy_o), 64'd1);
    check("sp_no_ack", DW'(bus.ack_o), 64'd0);
    tick();                       // cycle 4
    bus.slv_ack_i = 4'b1000;
    tick();                       // cycle 5
    bus.slv_ack_i = 4'b0000;
    check("sp_ack_c5", DW'(bus.ack_o), 64'd1);
    check("sp_rdata", bus.rdata_o, 64'h0123_4567_89AB_CDEF);
    tick();                       // cycle 6: IDLE, held req sampled here
    check("sp_idle_sel", DW'(bus.sel_o), 64'd0);
    check("sp_idle_busy", DW'(bus.busy_o), 64'd0);
    tick();                       // cycle 7
    bus.req_i = 1'b0;
    check("sp_reaccept", DW'(bus.sel_o), 64'd8);
    bus.slv_ack_i = 4'b1000;
    tick();
    bus.slv_ack_i = 4'b0000;
    tick();

    // Reset in cycle 2 of a RAM read
    request(1'b0, 4'b0001, 64'd0);
    tick();                       // cycle 1
    bus.req_i = 1'b0;
    tick();                       // cycle 2
    rst_n = 1'b0;
    tick();                       // cycle 3
    rst_n = 1'b1;
    check("mr_sel", DW'(bus.sel_o), 64'd0);
    check("mr_rdata", bus.rdata_o, 64'd0);
    check("mr_busy", DW'(bus.busy_o), 64'd0);
    bus.slv_ack_i = 4'b0001;
    tick();                       // cycle 4
    bus.slv_ack_i = 4'b0000;
    check("mr_no_ack", DW'(bus.ack_o), 64'd0);
    check("mr_busy2", DW'(bus.busy_o), 64'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.req_i   = 1'($urandom_range(0, 1));
      bus.we_i    = 1'($urandom_range(0, 1));
      bus.wdata_i = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0)
        bus.cs_i = 4'b0001 << $urandom_range(0, 3);
      else
        bus.cs_i = 4'($urandom_range(0, 15));
      bus.slv_ack_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      for (int n = 0; n < CS; n++)
        bus.slv_rdata_i[n*DW +: DW] = {$urandom(), $urandom()};
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/as_bus_resp.md
Name: as_bus_resp

Overview:
- Data-bus access controller directly downstream of the address decoder (as_decode).
- Takes the one-hot chip-select vector for each core load/store and registers the access towards the selected slave (RAM, GPIO, QSPI, CGU).
- Waits for that slave's acknowledge and returns read data, acknowledge and error to the core.
- Flags unmapped addresses (no or multiple selects) and slaves that never acknowledge (timeout).

Parameters:
- DW, 64: data width in bits.
- CS, 4: number of chip selects / slaves; equals as_pack chipsel.
- TIMEOUT, 16: maximum ACCESS cycles without slave ack before an error response; legal range 2..255.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_i  in  1  core access request; sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- wdata_i  in  DW  write data; sampled with req_i.
- cs_i  in  CS  one-hot chip select from as_decode; sampled with req_i.
- sel_o  out  CS  registered slave select; held through ACCESS.
- we_o  out  1  registered write enable to slaves; valid while sel_o != 0.
- wdata_o  out  DW  registered write data to slaves.
- slv_rdata_i  in  CS*DW  slave read data, slave n at bits [n*DW +: DW].
- slv_ack_i  in  CS  per-slave acknowledge, single-cycle pulse.
- rdata_o  out  DW  read data to the core.
- ack_o  out  1  single-cycle completion pulse to the core.
- err_o  out  1  qualifies ack_o; 1 = unmapped or timeout.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_ni=0 at a rising edge forces, from the next cycle:
  - state IDLE;
  - sel_o, we_o, wdata_o, rdata_o, ack_o, err_o, busy_o, timeout counter all 0.
  - This applies in any state, including mid-ACCESS; the aborted access produces no ack_o.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - req_i=1 with cs_i exactly one-hot: latch cs_i into sel_o, we_i into we_o, wdata_i into wdata_o; clear counter; go to ACCESS.
  - req_i=1 with cs_i zero or not one-hot: go to ERR; sel_o stays 0.
- ACCESS (sel_o asserted):
  - Counter increments each cycle.
  - slv_ack_i[n] with sel_o[n]=1: capture slv_rdata_i slice n into rdata_o (reads only; writes leave rdata_o unchanged); clear sel_o and we_o; go to RESP.
  - Otherwise, counter reaching TIMEOUT: clear sel_o and we_o; set rdata_o to 0; go to ERR.
  - Ack and timeout in the same cycle: ack wins.
- RESP: ack_o=1, err_o=0 for exactly one cycle; then IDLE.
- ERR: ack_o=1, err_o=1 for exactly one cycle; rdata_o=0; then IDLE.
- Latency:
  - Request accepted in cycle 0; sel_o high from cycle 1.
  - Slave ack in cycle k (k>=1) gives ack_o in cycle k+1; minimum 2 cycles.
  - Unmapped access: ack_o/err_o in cycle 1.
  - Timeout: ack_o/err_o in cycle TIMEOUT+1.
- req_i is ignored in ACCESS, RESP and ERR. A new request is accepted the cycle after ack_o, when the state is IDLE again; no back-to-back issue in the RESP cycle.
- Ignored acknowledges:
  - slv_ack_i from non-selected slaves, in any state;
  - slv_ack_i arriving in IDLE, RESP or ERR.
- rdata_o holds its value between accesses; core samples it only when ack_o=1 and err_o=0.
- Counter width: $clog2(TIMEOUT+1); saturation is never reached because ACCESS exits at TIMEOUT.

Test Plan:
- Read RAM: req_i=1, we_i=0, cs_i=0001; slv_rdata_i[63:0]=64'hDEADBEEF_CAFEF00D; slv_ack_i=0001 in cycle 3 -> sel_o=0001 in cycles 1-3; ack_o=1, err_o=0, rdata_o=64'hDEADBEEF_CAFEF00D in cycle 4.
- Write GPIO: we_i=1, cs_i=0010, wdata_i=64'h5A; ack in cycle 1 -> we_o=1, wdata_o=64'h5A in cycle 1; ack_o in cycle 2; rdata_o unchanged.
- Unmapped: cs_i=0000, then cs_i=0110 -> sel_o stays 0; ack_o=1, err_o=1 in cycle 1 each time; rdata_o=0.
- Timeout: cs_i=0100 (QSPI), no slv_ack_i -> sel_o high in cycles 1-16; ack_o=1, err_o=1 in cycle 17; busy_o low in cycle 18.
- Spurious and overlapping events:
  - Access to CGU (cs_i=1000); slv_ack_i=0001 in cycle 2 -> ignored, still ACCESS.
  - slv_ack_i=1000 in cycle 4 -> ack_o in cycle 5.
  - req_i held high during the access -> not accepted until IDLE.
- Reset mid-access: rst_ni=0 in cycle 2 of a RAM read -> all outputs 0 from cycle 3, no ack_o; a slave ack arriving after reset is ignored.
